// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the CDC handshake transmitter.
// The FSM state encoding is one-hot and the mode constants select 4-phase or 2-phase signalling.
package cdc_hs_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ASSERT   = 3'b010,
    DEASSERT = 3'b100
  } hs_state_e;

  localparam int HS_MODE_4PHASE = 0;
  localparam int HS_MODE_2PHASE = 1;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Producer and RX-handshake bundle of cdc_handshake_tx.
// The slave modport is the transmitter's view. The master modport is the environment (producer plus receiver).
interface cdc_handshake_tx_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          ack_i;
  logic          req_o;
  logic [DW-1:0] req_data_o;
  logic          done_o;
  logic          busy_o;
  logic [LW-1:0] level_o;

  modport master (
    output valid_i, data_i, ack_i,
    input  ready_o, req_o, req_data_o, done_o, busy_o, level_o
  );

  modport slave (
    input  valid_i, data_i, ack_i,
    output ready_o, req_o, req_data_o, done_o, busy_o, level_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, wrapping pointers and an occupancy counter.
// The head word is presented on rd_data whenever the FIFO is non-empty.
module sync_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Buffered CDC handshake transmitter. A FIFO feeds a req/ack FSM that sends one word per transaction.
// The ack is synchronised through SYNC_STAGES flops. Signalling is 4-phase (TWO_PHASE=0) or 2-phase toggle.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TWO_PHASE   = HS_MODE_4PHASE
) (
  input logic                clk_i,
  input logic                rst_n,
  cdc_handshake_tx_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  hs_state_e              state_q;
  logic                   req_q;
  logic [DW-1:0]          req_data_q;
  logic                   done_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [DW-1:0]          fifo_head;
  logic [LW-1:0]          fifo_level;

  // The ack comes from another clock domain; only the last synchroniser stage is used.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_i};
  end
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Pop only from IDLE, so the FSM loads a new word only after the previous one has completed.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push    (bus.valid_i && !fifo_full),
    .wr_data (bus.data_i),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      req_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            req_data_q <= fifo_head;
            req_q      <= (TWO_PHASE == HS_MODE_2PHASE) ? ~req_q : 1'b1;
            state_q    <= ASSERT;
          end
        end
        ASSERT: begin
          if (TWO_PHASE == HS_MODE_2PHASE) begin
            if (ack_s == req_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= DEASSERT;
          end
        end
        DEASSERT: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_o      = req_q;
  assign bus.req_data_o = req_data_q;
  assign bus.done_o     = done_q;
  assign bus.ready_o    = !fifo_full;
  assign bus.busy_o     = (state_q != IDLE) || !fifo_empty;
  assign bus.level_o    = fifo_level;

endmodule
